// File: rtl/cv_pad_emu_if.sv
// cv_pad_emu_if: signal bundle between the host input layer, the console
// controller port and the cv_pad_emu controller emulator.
//   ctrl_p5_i / ctrl_p8_i     console select pins 5 and 8, per port [2:1]
//   joy_p1_i / joy_p2_i       {fire_r, fire_l, right, left, down, up}, active high
//   key_p1_i / key_p2_i       keypad, bits 0-9 digits, 10 '*', 11 '#', active high
//   spin_p1_i / spin_p2_i     signed spinner deltas
//   spin_stb_i                per-port delta strobe [2:1]
//   ctrl_p1_o..ctrl_p6_o      active-low data pins back to the console [2:1]
//   ctrl_p7_o / ctrl_p9_o     spinner quadrature phases A / B [2:1]
// master = host + console side, slave = the emulator.
interface cv_pad_emu_if #(
  parameter int ACC_W = 8
);
  logic [2:1]              ctrl_p5_i;
  logic [2:1]              ctrl_p8_i;
  logic [5:0]              joy_p1_i;
  logic [5:0]              joy_p2_i;
  logic [11:0]             key_p1_i;
  logic [11:0]             key_p2_i;
  logic signed [ACC_W-1:0] spin_p1_i;
  logic signed [ACC_W-1:0] spin_p2_i;
  logic [2:1]              spin_stb_i;
  logic [2:1]              ctrl_p1_o;
  logic [2:1]              ctrl_p2_o;
  logic [2:1]              ctrl_p3_o;
  logic [2:1]              ctrl_p4_o;
  logic [2:1]              ctrl_p6_o;
  logic [2:1]              ctrl_p7_o;
  logic [2:1]              ctrl_p9_o;

  modport master (
    output ctrl_p5_i, ctrl_p8_i, joy_p1_i, joy_p2_i, key_p1_i, key_p2_i,
           spin_p1_i, spin_p2_i, spin_stb_i,
    input  ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o,
           ctrl_p7_o, ctrl_p9_o
  );

  modport slave (
    input  ctrl_p5_i, ctrl_p8_i, joy_p1_i, joy_p2_i, key_p1_i, key_p2_i,
           spin_p1_i, spin_p2_i, spin_stb_i,
    output ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o,
           ctrl_p7_o, ctrl_p9_o
  );
endinterface

// File: rtl/cv_pad_emu.sv
// cv_pad_emu: emulates two ColecoVision hand controllers on the 9-pin port.
// The console selects keypad/joystick mode through pins 5/8; this block
// answers on data pins 1-4 and 6 and drives the spinner quadrature on 7/9.
// Ports:
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   clk_en_3m58_i  3.58 MHz clock enable, paces the spinner prescaler
//   pad            cv_pad_emu_if slave (selects, host state, pad outputs)
// Array index 0 is controller port 1, index 1 is controller port 2.
module cv_pad_emu #(
  parameter int SPIN_DIV = 64,
  parameter int ACC_W    = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_3m58_i,
  cv_pad_emu_if.slave pad
);

  localparam int PRE_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SPIN_DIV - 1);
  // Two guard bits keep acc + delta - 1 exact before clamping.
  localparam logic signed [ACC_W+1:0] SUM_MAX  = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] SUM_MIN  = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W+1:0] SUM_ONE  = {{(ACC_W+1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W+1:0] SUM_NEG1 = {(ACC_W+2){1'b1}};

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] sum);
    logic signed [ACC_W+1:0] clip;
    if (sum > SUM_MAX)      clip = SUM_MAX;
    else if (sum < SUM_MIN) clip = SUM_MIN;
    else                    clip = sum;
    return clip[ACC_W-1:0];
  endfunction

  // Quadrature {A,B}: forward 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    case (ph)
      2'b00:   return fwd ? 2'b01 : 2'b10;
      2'b01:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b10 : 2'b01;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'hA;
      4'd1:    return 4'hD;
      4'd2:    return 4'h7;
      4'd3:    return 4'hC;
      4'd4:    return 4'h2;
      4'd5:    return 4'h3;
      4'd6:    return 4'hE;
      4'd7:    return 4'h5;
      4'd8:    return 4'h1;
      4'd9:    return 4'hB;
      4'd10:   return 4'h6;
      4'd11:   return 4'h9;
      default: return 4'hF;
    endcase
  endfunction

  // Scan from the top so the lowest pressed index is the last one written.
  function automatic logic [3:0] key_nibble(input logic [11:0] key);
    logic [3:0] n;
    n = 4'hF;
    for (int i = 11; i >= 0; i--) begin
      if (key[i]) n = key_code(4'(i));
    end
    return n;
  endfunction

  // Returns {p6, p4, p3, p2, p1}; keypad nibble maps as {p3,p2,p4,p1} = N.
  function automatic logic [4:0] data_pins(input logic p5, input logic p8,
                                           input logic [5:0] joy, input logic [11:0] key);
    logic [3:0] n;
    n = key_nibble(key);
    if (p5 && !p8)      return {~joy[4], ~joy[3], ~joy[2], ~joy[1], ~joy[0]};
    else if (!p5 && p8) return {~joy[5], n[1], n[3], n[2], n[0]};
    else                return 5'b11111;
  endfunction

  logic [1:0]              p5_s1_q, p5_s1_d, p5_s2_q, p5_s2_d;
  logic [1:0]              p8_s1_q, p8_s1_d, p8_s2_q, p8_s2_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic                    step;
  logic [5:0]              joy [2];
  logic [11:0]             key [2];
  logic signed [ACC_W-1:0] delta [2];
  logic [1:0]              spin_stb;
  logic                    fwd [2];
  logic                    bwd [2];
  logic signed [ACC_W+1:0] dir [2];
  logic signed [ACC_W+1:0] add [2];
  logic signed [ACC_W+1:0] sum [2];
  logic signed [ACC_W-1:0] acc_q [2];
  logic signed [ACC_W-1:0] acc_d [2];
  logic [1:0]              ph_q [2];
  logic [1:0]              ph_d [2];
  logic [4:0]              data_q [2];
  logic [4:0]              data_d [2];

  always_comb begin
    joy[0]   = pad.joy_p1_i;
    joy[1]   = pad.joy_p2_i;
    key[0]   = pad.key_p1_i;
    key[1]   = pad.key_p2_i;
    delta[0] = pad.spin_p1_i;
    delta[1] = pad.spin_p2_i;
    spin_stb = pad.spin_stb_i;

    // Select synchronisers, stage 0 -> 1 -> 2
    p5_s1_d = pad.ctrl_p5_i;
    p8_s1_d = pad.ctrl_p8_i;
    p5_s2_d = p5_s1_q;
    p8_s2_d = p8_s1_q;

    pre_d = pre_q;
    step  = 1'b0;
    if (clk_en_3m58_i) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    for (int i = 0; i < 2; i++) begin
      // Step direction is taken from the accumulator before any new delta.
      fwd[i]  = step && !acc_q[i][ACC_W-1] && (acc_q[i] != '0);
      bwd[i]  = step && acc_q[i][ACC_W-1];
      dir[i]  = fwd[i] ? SUM_ONE : (bwd[i] ? SUM_NEG1 : '0);
      add[i]  = spin_stb[i] ? {{2{delta[i][ACC_W-1]}}, delta[i]} : '0;
      sum[i]  = {{2{acc_q[i][ACC_W-1]}}, acc_q[i]} + add[i] - dir[i];
      acc_d[i] = sat_acc(sum[i]);
      ph_d[i]  = fwd[i] ? phase_step(ph_q[i], 1'b1) :
                 bwd[i] ? phase_step(ph_q[i], 1'b0) : ph_q[i];
      data_d[i] = data_pins(p5_s2_q[i], p8_s2_q[i], joy[i], key[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      p5_s1_q <= 2'b11;
      p5_s2_q <= 2'b11;
      p8_s1_q <= 2'b11;
      p8_s2_q <= 2'b11;
      pre_q   <= '0;
      acc_q   <= '{default: '0};
      ph_q    <= '{default: 2'b00};
      data_q  <= '{default: 5'b11111};
    end else begin
      p5_s1_q <= p5_s1_d;
      p5_s2_q <= p5_s2_d;
      p8_s1_q <= p8_s1_d;
      p8_s2_q <= p8_s2_d;
      pre_q   <= pre_d;
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
    end
  end

  assign pad.ctrl_p1_o = {data_q[1][0], data_q[0][0]};
  assign pad.ctrl_p2_o = {data_q[1][1], data_q[0][1]};
  assign pad.ctrl_p3_o = {data_q[1][2], data_q[0][2]};
  assign pad.ctrl_p4_o = {data_q[1][3], data_q[0][3]};
  assign pad.ctrl_p6_o = {data_q[1][4], data_q[0][4]};
  assign pad.ctrl_p7_o = {ph_q[1][1], ph_q[0][1]};
  assign pad.ctrl_p9_o = {ph_q[1][0], ph_q[0][0]};

endmodule

// File: tb/tb_cv_pad_emu.sv
// Self-checking bench for cv_pad_emu: vector table, hand-written latency and
// spinner sequences, then randomized stimulus against a behavioural model.
module tb_cv_pad_emu;
  localparam int SPIN_DIV = 2;
  localparam int ACC_W    = 8;
  localparam int LIM      = 2 ** (ACC_W - 1);

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  cv_pad_emu_if #(.ACC_W(ACC_W)) pad ();

  cv_pad_emu #(.SPIN_DIV(SPIN_DIV), .ACC_W(ACC_W)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .clk_en_3m58_i(clk_en),
    .pad          (pad)
  );

  typedef struct {
    logic [2:1]  p5;
    logic [2:1]  p8;
    logic [5:0]  joy1;
    logic [5:0]  joy2;
    logic [11:0] key1;
    logic [11:0] key2;
    logic [4:0]  exp1;   // {p1,p2,p3,p4,p6}
    logic [4:0]  exp2;
  } vec_t;
  vec_t vecs [8];

  // Reference model state
  int         m_acc [2];
  int         m_pos [2];
  int         m_cnt;
  logic [3:0] sel_hist [$];   // {p8[2:1], p5[2:1]} per clock edge
  logic [4:0] m_data [2];
  int         chg [2];
  logic [1:0] last_ph [2];

  function automatic logic [3:0] key_nib(input logic [11:0] key);
    logic [3:0] tab [12];
    tab = '{4'hA, 4'hD, 4'h7, 4'hC, 4'h2, 4'h3, 4'hE, 4'h5, 4'h1, 4'hB, 4'h6, 4'h9};
    for (int i = 0; i < 12; i++) if (key[i]) return tab[i];
    return 4'hF;
  endfunction

  // {p1,p2,p3,p4,p6}
  function automatic logic [4:0] exp_data(input logic p5, input logic p8,
                                          input logic [5:0] joy, input logic [11:0] key);
    logic [3:0] n;
    if (p5 && !p8) return {~joy[0], ~joy[1], ~joy[2], ~joy[3], ~joy[4]};
    if (!p5 && p8) begin
      n = key_nib(key);
      return {n[0], n[2], n[3], n[1], ~joy[5]};
    end
    return 5'b11111;
  endfunction

  function automatic logic [1:0] phase_of(input int pos);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10};
    return seq[((pos % 4) + 4) % 4];
  endfunction

  function automatic logic [6:0] get_out(input int p);
    return {pad.ctrl_p1_o[p+1], pad.ctrl_p2_o[p+1], pad.ctrl_p3_o[p+1], pad.ctrl_p4_o[p+1],
            pad.ctrl_p6_o[p+1], pad.ctrl_p7_o[p+1], pad.ctrl_p9_o[p+1]};
  endfunction

  task automatic check(input string name, input int port, input logic [15:0] act,
                       input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s port%0d: got %h, expected %h (t=%0t)", name, port + 1, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0]  old;
    logic [5:0]  joy [2];
    logic [11:0] key [2];
    int          d;
    int          dir;
    bit          stp;
    if (rst) begin
      m_acc = '{0, 0};
      m_pos = '{0, 0};
      m_cnt = 0;
      sel_hist = '{4'hF, 4'hF};
      m_data = '{5'h1F, 5'h1F};
      return;
    end
    joy = '{pad.joy_p1_i, pad.joy_p2_i};
    key = '{pad.key_p1_i, pad.key_p2_i};
    // Data pins reflect the select seen two edges ago.
    old = sel_hist[sel_hist.size() - 2];
    for (int p = 0; p < 2; p++) m_data[p] = exp_data(old[p], old[p+2], joy[p], key[p]);
    sel_hist.push_back({pad.ctrl_p8_i, pad.ctrl_p5_i});
    if (sel_hist.size() > 3) void'(sel_hist.pop_front());

    stp = clk_en && (m_cnt == SPIN_DIV - 1);
    if (clk_en) m_cnt = (m_cnt + 1) % SPIN_DIV;
    for (int p = 0; p < 2; p++) begin
      dir = 0;
      if (stp && m_acc[p] > 0) dir = 1;
      if (stp && m_acc[p] < 0) dir = -1;
      m_pos[p] += dir;
      m_acc[p] -= dir;
      if (pad.spin_stb_i[p+1]) begin
        d = (p == 0) ? int'(pad.spin_p1_i) : int'(pad.spin_p2_i);
        m_acc[p] += d;
        if (m_acc[p] > LIM - 1) m_acc[p] = LIM - 1;
        if (m_acc[p] < -LIM)    m_acc[p] = -LIM;
      end
    end
  endtask

  task automatic tick();
    logic [6:0] act;
    @(posedge clk);
    model_edge();
    #1;
    for (int p = 0; p < 2; p++) begin
      act = get_out(p);
      check("cycle", p, 16'(act), 16'({m_data[p], phase_of(m_pos[p])}));
      if (act[1:0] != last_ph[p]) chg[p]++;
      last_ph[p] = act[1:0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chg = '{0, 0};
    last_ph = '{2'b00, 2'b00};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] seq;
    int         prev;

    vecs[0] = '{2'b11, 2'b10, 6'b010101, 6'b111111, 12'h000, 12'h000, 5'b01010, 5'b11111};
    vecs[1] = '{2'b01, 2'b10, 6'b001010, 6'b000000, 12'h000, 12'h020, 5'b10101, 5'b10011};
    vecs[2] = '{2'b01, 2'b10, 6'b000011, 6'b100000, 12'h000, 12'h820, 5'b00111, 5'b10010};
    vecs[3] = '{2'b01, 2'b10, 6'b001100, 6'b000000, 12'h000, 12'h000, 5'b11001, 5'b11111};
    vecs[4] = '{2'b00, 2'b11, 6'b000000, 6'b100000, 12'h400, 12'h001, 5'b01011, 5'b00110};
    vecs[5] = '{2'b00, 2'b00, 6'b111111, 6'b111111, 12'hFFF, 12'hFFF, 5'b11111, 5'b11111};
    vecs[6] = '{2'b10, 2'b01, 6'b111111, 6'b010000, 12'h800, 12'hFFF, 5'b10100, 5'b11110};
    vecs[7] = '{2'b00, 2'b11, 6'b000000, 6'b011111, 12'h280, 12'h008, 5'b11001, 5'b01101};

    rst = 1'b1;
    clk_en = 1'b0;
    pad.ctrl_p5_i = 2'b11;
    pad.ctrl_p8_i = 2'b11;
    pad.joy_p1_i = '0;
    pad.joy_p2_i = '0;
    pad.key_p1_i = '0;
    pad.key_p2_i = '0;
    pad.spin_p1_i = '0;
    pad.spin_p2_i = '0;
    pad.spin_stb_i = '0;
    chg = '{0, 0};
    last_ph = '{2'b00, 2'b00};
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    for (int p = 0; p < 2; p++) check("reset", p, 16'(get_out(p)), 16'(7'b11111_00));

    // Mode decode vectors
    for (int v = 0; v < 8; v++) begin
      pad.ctrl_p5_i = vecs[v].p5;
      pad.ctrl_p8_i = vecs[v].p8;
      pad.joy_p1_i  = vecs[v].joy1;
      pad.joy_p2_i  = vecs[v].joy2;
      pad.key_p1_i  = vecs[v].key1;
      pad.key_p2_i  = vecs[v].key2;
      repeat (3) tick();
      check("vec_data", 0, 16'(get_out(0) >> 2), 16'(vecs[v].exp1));
      check("vec_data", 1, 16'(get_out(1) >> 2), 16'(vecs[v].exp2));
    end

    // Select latency: KEY -> JOY on port 1
    pad.key_p1_i = 12'h100;
    pad.joy_p1_i = 6'b000001;
    repeat (3) tick();
    check("lat_key", 0, 16'(get_out(0) >> 2), 16'(5'b10001));
    pad.ctrl_p5_i = 2'b01;
    pad.ctrl_p8_i = 2'b10;
    tick();
    check("lat_edge1", 0, 16'(get_out(0) >> 2), 16'(5'b10001));
    tick();
    check("lat_edge2", 0, 16'(get_out(0) >> 2), 16'(5'b10001));
    tick();
    check("lat_edge3", 0, 16'(get_out(0) >> 2), 16'(5'b01111));

    // Spinner +3: three forward steps then hold
    pad.ctrl_p5_i = 2'b00;
    pad.ctrl_p8_i = 2'b00;
    do_reset();
    pad.spin_p1_i = 8'sd3;
    pad.spin_stb_i = 2'b01;
    tick();
    pad.spin_stb_i = 2'b00;
    clk_en = 1'b1;
    seq = '0;
    for (int c = 0; c < 12; c++) begin
      prev = chg[0];
      tick();
      if (chg[0] != prev) seq = {seq[3:0], last_ph[0]};
    end
    check("spin_steps", 0, 16'(chg[0]), 16'd3);
    check("spin_seq", 0, 16'(seq), 16'(6'b01_11_10));
    check("spin_other", 1, 16'(chg[1]), 16'd0);

    // Saturation: -128 then -5 leaves exactly 128 backward steps
    do_reset();
    clk_en = 1'b0;
    pad.spin_p1_i = -8'sd128;
    pad.spin_stb_i = 2'b01;
    tick();
    pad.spin_p1_i = -8'sd5;
    tick();
    pad.spin_stb_i = 2'b00;
    clk_en = 1'b1;
    chg = '{0, 0};
    repeat (300) tick();
    check("sat_steps", 0, 16'(chg[0]), 16'd128);
    check("sat_phase", 0, 16'(get_out(0) & 7'h3), 16'(2'b00));

    // Strobe +1 on a step cycle with acc = 2
    do_reset();
    clk_en = 1'b0;
    pad.spin_p1_i = 8'sd2;
    pad.spin_stb_i = 2'b01;
    tick();
    pad.spin_stb_i = 2'b00;
    clk_en = 1'b1;
    tick();
    chg = '{0, 0};
    pad.spin_p1_i = 8'sd1;
    pad.spin_stb_i = 2'b01;
    tick();
    pad.spin_stb_i = 2'b00;
    check("same_cyc_phase", 0, 16'(get_out(0) & 7'h3), 16'(2'b01));
    repeat (20) tick();
    check("same_cyc_steps", 0, 16'(chg[0]), 16'd3);
    check("same_cyc_final", 0, 16'(get_out(0) & 7'h3), 16'(2'b10));

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      clk_en = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      pad.spin_stb_i = 2'($urandom);
      pad.spin_p1_i = ACC_W'($urandom);
      pad.spin_p2_i = ACC_W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        pad.ctrl_p5_i = 2'($urandom);
        pad.ctrl_p8_i = 2'($urandom);
      end
      pad.joy_p1_i = 6'($urandom);
      pad.joy_p2_i = 6'($urandom);
      pad.key_p1_i = 12'($urandom) >> $urandom_range(0, 12);
      pad.key_p2_i = 12'($urandom) >> $urandom_range(0, 12);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
